// File: rtl/conv_pkg.sv
// conv_pkg: shared size codes, pixel-bus geometry, lane indexing and FSM states for the convolution path
package conv_pkg;
  localparam logic [1:0] MAT_2X2 = 2'b00;
  localparam logic [1:0] MAT_3X3 = 2'b01;
  localparam logic [1:0] MAT_4X4 = 2'b10;
  localparam logic [1:0] MAT_5X5 = 2'b11;
  localparam int PIX_BUS_W = 200;
  localparam int LANES = 25;
  localparam int LANE_W = 8;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
  function automatic logic [4:0] lane_idx(input logic [2:0] r, input logic [2:0] c);
    return {2'b00, r} * 5'd5 + {2'b00, c};
  endfunction
endpackage

// File: rtl/region_addr_gen.sv
// region_addr_gen: row-major (r,c) walker producing bounds-checked image addresses and pad flags
module region_addr_gen import conv_pkg::*; #(
  parameter int ADDR_W = 17,
  parameter int DIM_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                step,
  input  logic [1:0]          matrix_size,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [DIM_W-1:0]    img_width,
  input  logic [DIM_W-1:0]    img_height,
  input  logic signed [DIM_W:0] win_x,
  input  logic signed [DIM_W:0] win_y,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   addr,
  output logic                pad,
  output logic [4:0]          lane,
  output logic                last
);
  logic [2:0] lim, r, c;
  logic [ADDR_W-1:0] base, row_off;
  logic [DIM_W-1:0] w, h;
  logic signed [DIM_W:0] wx, wy;
  logic signed [DIM_W+1:0] x, y;
  logic inb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lim <= '0;
      r <= '0;
      c <= '0;
      base <= '0;
      row_off <= '0;
      w <= '0;
      h <= '0;
      wx <= '0;
      wy <= '0;
    end else if (init) begin
      lim <= {1'b0, matrix_size} + 3'd1;
      r <= '0;
      c <= '0;
      base <= base_addr;
      w <= img_width;
      h <= img_height;
      wx <= win_x;
      wy <= win_y;
      // starting row offset needs one product; every later row is a single add
      row_off <= $signed({{(ADDR_W-DIM_W-1){win_y[DIM_W]}}, win_y}) * $signed({{(ADDR_W-DIM_W){1'b0}}, img_width});
    end else if (step) begin
      c <= (c == lim) ? 3'd0 : c + 3'd1;
      if (c == lim) begin
        r <= r + 3'd1;
        row_off <= row_off + {{(ADDR_W-DIM_W){1'b0}}, w};
      end
    end
  assign x = {wx[DIM_W], wx} + $signed({{(DIM_W-1){1'b0}}, c});
  assign y = {wy[DIM_W], wy} + $signed({{(DIM_W-1){1'b0}}, r});
  assign inb = !x[DIM_W+1] && !y[DIM_W+1] && (x[DIM_W:0] < {1'b0, w}) && (y[DIM_W:0] < {1'b0, h});
  assign rd_en = step & inb;
  assign pad = ~inb;
  assign addr = rd_en ? base + row_off + {{(ADDR_W-DIM_W-1){1'b0}}, x[DIM_W:0]} : '0;
  assign lane = lane_idx(r, c);
  assign last = (r == lim) && (c == lim);
endmodule

// File: rtl/region_loader.sv
// region_loader: fetches an NxN image region, zero-pads outside the image and packs it onto the 5x5 pixel bus
module region_loader import conv_pkg::*; #(
  parameter int ADDR_W = 17,
  parameter int DIM_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            matrix_size,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [DIM_W-1:0]      img_width,
  input  logic [DIM_W-1:0]      img_height,
  input  logic signed [DIM_W:0] win_x,
  input  logic signed [DIM_W:0] win_y,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_BUS_W-1:0]  pixel_out
);
  state_t state;
  logic init, pad, last, cap_v, cap_pad;
  logic [4:0] lane, cap_k;
  assign init = (state == IDLE) && start;
  region_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_gen (
    .clk(clk), .rst_n(rst_n), .init(init), .step(state == FETCH),
    .matrix_size(matrix_size), .base_addr(base_addr),
    .img_width(img_width), .img_height(img_height),
    .win_x(win_x), .win_y(win_y),
    .rd_en(mem_rd_en), .addr(mem_addr), .pad(pad), .lane(lane), .last(last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      out_valid <= 1'b0;
      pixel_out <= '0;
      cap_v <= 1'b0;
      cap_pad <= 1'b0;
      cap_k <= '0;
    end else begin
      cap_v <= state == FETCH;
      cap_pad <= pad;
      cap_k <= lane;
      // read data arrives one cycle after issue, so the lane index rides one stage behind
      if (cap_v) pixel_out[cap_k*LANE_W +: LANE_W] <= cap_pad ? '0 : mem_rdata;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          busy <= 1'b1;
          pixel_out <= '0;
        end
        FETCH: if (last) state <= DRAIN;
        DRAIN: begin
          state <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) begin
          state <= IDLE;
          busy <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
